ocp_burst_slave: RTL and testbench

//  OCP responder (slave) at the far end of ocp_if. Accepts master commands
//  (maddr/mcmd/mburstlength/mburstseq/mbyteen) plus request-phase write data,
//  and serves them from an internal word-addressed memory. It supports INCR

---
 rtl/ocp_if.sv | 29 ++
 rtl/ocp_burst_slave.sv | 164 ++++++++++++++++
 tb/tb_ocp_burst_slave.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ocp_if.sv
// OCP request/response signal bundle between one master and one slave.
// Master drives the command phase and response accept; slave answers.
interface ocp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BLEN_WIDTH = 4
);
    logic [ADDR_WIDTH-1:0]   maddr;
    logic [2:0]              mcmd;
    logic [BLEN_WIDTH-1:0]   mburstlength;
    logic [2:0]              mburstseq;
    logic [DATA_WIDTH/8-1:0] mbyteen;
    logic [DATA_WIDTH-1:0]   mdata;
    logic                    scmdaccept;
    logic [1:0]              sresp;
    logic [DATA_WIDTH-1:0]   sdata;
    logic                    sresplast;
    logic                    mrespaccept;

    modport master (
        output maddr, mcmd, mburstlength, mburstseq, mbyteen, mdata, mrespaccept,
        input  scmdaccept, sresp, sdata, sresplast
    );

    modport slave (
        input  maddr, mcmd, mburstlength, mburstseq, mbyteen, mdata, mrespaccept,
        output scmdaccept, sresp, sdata, sresplast
    );
endinterface

// File: rtl/ocp_burst_slave.sv
// OCP slave serving INCR read/write bursts from an internal word-addressed memory.
// Write bursts get a single DVA/ERR response; read bursts return one DVA per beat.
module ocp_burst_slave #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int BLEN_WIDTH = 4
) (
    input logic  clk,
    input logic  rst,
    ocp_if.slave bus
);
    localparam int BE_W  = DATA_WIDTH / 8;
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;

    localparam logic [1:0] RESP_NULL = 2'b00;
    localparam logic [1:0] RESP_DVA  = 2'b01;
    localparam logic [1:0] RESP_ERR  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WR_BURST,
        S_RESP,
        S_RD_BURST
    } state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
    logic [BLEN_WIDTH-1:0] r_count, w_count_nxt;
    logic [1:0]            r_sresp, w_sresp_nxt;
    logic [DATA_WIDTH-1:0] r_sdata, w_sdata_nxt;
    logic                  r_sresplast, w_sresplast_nxt;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic                  w_first_legal;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    assign w_first_legal = (bus.mburstseq == 3'b000) && (bus.mburstlength != '0) &&
                           ((bus.mcmd == CMD_WR) || (bus.mcmd == CMD_RD));

    assign bus.scmdaccept = (r_state == S_IDLE) || (r_state == S_WR_BURST);
    assign bus.sresp      = r_sresp;
    assign bus.sdata      = r_sdata;
    assign bus.sresplast  = r_sresplast;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves a value unassigned (no latches).
        w_state_nxt     = r_state;
        w_addr_nxt      = r_addr;
        w_count_nxt     = r_count;
        w_sresp_nxt     = r_sresp;
        w_sdata_nxt     = r_sdata;
        w_sresplast_nxt = r_sresplast;
        w_we            = 1'b0;
        w_waddr         = r_addr;

        unique case (r_state)
            S_IDLE: begin
                if (bus.mcmd != CMD_IDLE) begin
                    if (!w_first_legal) begin
                        w_state_nxt     = S_RESP;
                        w_sresp_nxt     = RESP_ERR;
                        w_sresplast_nxt = 1'b1;
                    end else if (bus.mcmd == CMD_WR) begin
                        w_we        = 1'b1;
                        w_waddr     = bus.maddr;
                        w_addr_nxt  = bus.maddr + ADDR_WIDTH'(1);
                        w_count_nxt = bus.mburstlength - BLEN_WIDTH'(1);
                        if (bus.mburstlength == BLEN_WIDTH'(1)) begin
                            w_state_nxt     = S_RESP;
                            w_sresp_nxt     = RESP_DVA;
                            w_sresplast_nxt = 1'b1;
                        end else begin
                            w_state_nxt = S_WR_BURST;
                        end
                    end else begin
                        // First read beat is registered here; r_count tracks beats still to present.
                        w_state_nxt     = S_RD_BURST;
                        w_sresp_nxt     = RESP_DVA;
                        w_sdata_nxt     = r_mem[bus.maddr];
                        w_sresplast_nxt = (bus.mburstlength == BLEN_WIDTH'(1));
                        w_addr_nxt      = bus.maddr + ADDR_WIDTH'(1);
                        w_count_nxt     = bus.mburstlength - BLEN_WIDTH'(1);
                    end
                end
            end

            S_WR_BURST: begin
                if (bus.mcmd == CMD_WR) begin
                    w_we        = 1'b1;
                    w_addr_nxt  = r_addr + ADDR_WIDTH'(1);
                    w_count_nxt = r_count - BLEN_WIDTH'(1);
                    if (r_count == BLEN_WIDTH'(1)) begin
                        w_state_nxt     = S_RESP;
                        w_sresp_nxt     = RESP_DVA;
                        w_sresplast_nxt = 1'b1;
                    end
                end else if (bus.mcmd != CMD_IDLE) begin
                    w_state_nxt     = S_RESP;
                    w_sresp_nxt     = RESP_ERR;
                    w_sresplast_nxt = 1'b1;
                end
            end

            S_RESP: begin
                if (bus.mrespaccept) begin
                    w_state_nxt     = S_IDLE;
                    w_sresp_nxt     = RESP_NULL;
                    w_sresplast_nxt = 1'b0;
                end
            end

            S_RD_BURST: begin
                if (bus.mrespaccept) begin
                    if (r_sresplast) begin
                        w_state_nxt     = S_IDLE;
                        w_sresp_nxt     = RESP_NULL;
                        w_sresplast_nxt = 1'b0;
                    end else begin
                        w_sdata_nxt     = r_mem[r_addr];
                        w_addr_nxt      = r_addr + ADDR_WIDTH'(1);
                        w_count_nxt     = r_count - BLEN_WIDTH'(1);
                        w_sresplast_nxt = (r_count == BLEN_WIDTH'(1));
                    end
                end
            end

            default: w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_count     <= '0;
            r_sresp     <= RESP_NULL;
            r_sdata     <= '0;
            r_sresplast <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_addr      <= w_addr_nxt;
            r_count     <= w_count_nxt;
            r_sresp     <= w_sresp_nxt;
            r_sdata     <= w_sdata_nxt;
            r_sresplast <= w_sresplast_nxt;
        end
    end

    // NOTE: the memory must read back as zero after reset, so it is built from resettable flops, not a RAM macro.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
        end else if (w_we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (bus.mbyteen[b]) r_mem[w_waddr][8*b +: 8] <= bus.mdata[8*b +: 8];
            end
        end
    end
endmodule

// File: tb/tb_ocp_burst_slave.sv
// Directed bench for ocp_burst_slave: stimulus pushes expected response beats into a
// scoreboard queue; an independent monitor pops and compares each consumed beat.
module tb_ocp_burst_slave;
    localparam logic [2:0] CMD_IDLE = 3'b000;
    localparam logic [2:0] CMD_WR   = 3'b001;
    localparam logic [2:0] CMD_RD   = 3'b010;
    localparam logic [1:0] DVA      = 2'b01;
    localparam logic [1:0] ERR      = 2'b11;

    typedef struct {
        logic [1:0]  resp;
        logic        last;
        logic        chk;
        logic [31:0] data;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   tests = 0;
    int   fails = 0;
    exp_t sb[$];
    bit   mon_en = 1'b1;
    int   stall_beat = 0;
    int   stall_left = 0;

    ocp_if #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BLEN_WIDTH(4)) bus ();

    ocp_burst_slave #(.ADDR_WIDTH(5), .DATA_WIDTH(32), .BLEN_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic push(input logic [1:0] resp, input logic last, input logic chk,
                        input logic [31:0] data);
        exp_t e;
        e.resp = resp; e.last = last; e.chk = chk; e.data = data;
        sb.push_back(e);
    endtask

    // Drives one request beat and holds it until the slave accepts it.
    task automatic issue(input logic [2:0] cmd, input logic [4:0] addr, input logic [3:0] len,
                         input logic [2:0] seq, input logic [3:0] be, input logic [31:0] data);
        int n = 0;
        bus.mcmd = cmd; bus.maddr = addr; bus.mburstlength = len;
        bus.mburstseq = seq; bus.mbyteen = be; bus.mdata = data;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.scmdaccept && n < 200);
        check("cmd_accept", {31'd0, bus.scmdaccept}, 32'd1);
        @(posedge clk);
        #1 bus.mcmd = CMD_IDLE;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((sb.size() != 0 || bus.sresp != 2'b00) && n < 300) begin
            @(posedge clk);
            n++;
        end
        check("drain", sb.size(), 32'd0);
        idle(1);
    endtask

    // Monitor/responder: decides mrespaccept, then compares each consumed beat.
    initial begin
        int          beat_idx = 0;
        bit          hold = 0, post_last = 0, expect_more = 0, acc;
        logic [1:0]  h_resp;
        logic [31:0] h_data;
        logic        h_last;
        exp_t        e;
        bus.mrespaccept = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                beat_idx = 0; hold = 0; post_last = 0; expect_more = 0;
            end else begin
                if (post_last && mon_en) check("null_after_last", {30'd0, bus.sresp}, 32'd0);
                if (expect_more && mon_en) check("no_bubble", {31'd0, bus.sresp != 2'b00}, 32'd1);
                post_last = 0; expect_more = 0;
                if (bus.sresp != 2'b00) begin
                    acc = !(stall_left > 0 && beat_idx == stall_beat);
                    if (!acc) stall_left--;
                    bus.mrespaccept = acc;
                    if (mon_en) begin
                        check("scmdaccept_low", {31'd0, bus.scmdaccept}, 32'd0);
                        if (hold) begin
                            check("hold_resp", {30'd0, bus.sresp}, {30'd0, h_resp});
                            check("hold_data", bus.sdata, h_data);
                            check("hold_last", {31'd0, bus.sresplast}, {31'd0, h_last});
                        end
                    end
                    if (acc) begin
                        if (mon_en) begin
                            if (sb.size() == 0) begin
                                tests++; fails++;
                                $display("FAIL unexpected_beat: got resp %b data %h expected none",
                                         bus.sresp, bus.sdata);
                            end else begin
                                e = sb.pop_front();
                                check("resp", {30'd0, bus.sresp}, {30'd0, e.resp});
                                check("last", {31'd0, bus.sresplast}, {31'd0, e.last});
                                if (e.chk) check("sdata", bus.sdata, e.data);
                            end
                        end
                        if (bus.sresplast) begin
                            beat_idx = 0; post_last = 1;
                        end else begin
                            beat_idx++; expect_more = 1;
                        end
                        hold = 0;
                    end else begin
                        hold = 1; h_resp = bus.sresp; h_data = bus.sdata; h_last = bus.sresplast;
                    end
                end else begin
                    bus.mrespaccept = 1'b0;
                    hold = 0;
                end
            end
        end
    end

    initial begin
        bus.mcmd = CMD_IDLE; bus.maddr = '0; bus.mburstlength = '0;
        bus.mburstseq = '0; bus.mbyteen = '0; bus.mdata = '0;
        #1;
        check("rst_sresp", {30'd0, bus.sresp}, 32'd0);
        check("rst_sdata", bus.sdata, 32'd0);
        check("rst_sresplast", {31'd0, bus.sresplast}, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1 check("rel_scmdaccept", {31'd0, bus.scmdaccept}, 32'd1);

        // INCR write of 4 beats wrapping 30,31,0,1
        push(DVA, 1'b1, 1'b0, 32'h0);
        issue(CMD_WR, 5'd30, 4'd4, 3'b000, 4'hF, 32'hA0A0_A0A0);
        issue(CMD_WR, 5'd0,  4'd0, 3'b000, 4'hF, 32'hA1A1_A1A1);
        issue(CMD_WR, 5'd0,  4'd0, 3'b000, 4'hF, 32'hA2A2_A2A2);
        issue(CMD_WR, 5'd0,  4'd0, 3'b000, 4'hF, 32'hA3A3_A3A3);
        wait_drain();

        // Read it back with a two-cycle stall on the second beat
        stall_beat = 1; stall_left = 2;
        push(DVA, 1'b0, 1'b1, 32'hA0A0_A0A0);
        push(DVA, 1'b0, 1'b1, 32'hA1A1_A1A1);
        push(DVA, 1'b0, 1'b1, 32'hA2A2_A2A2);
        push(DVA, 1'b1, 1'b1, 32'hA3A3_A3A3);
        issue(CMD_RD, 5'd30, 4'd4, 3'b000, 4'h0, 32'h0);
        wait_drain();
        check("stall_used", stall_left, 32'd0);

        // Byte-lane gating on a single write, then single read
        push(DVA, 1'b1, 1'b0, 32'h0);
        issue(CMD_WR, 5'd5, 4'd1, 3'b000, 4'b0011, 32'h1234_5678);
        push(DVA, 1'b1, 1'b1, 32'h0000_5678);
        issue(CMD_RD, 5'd5, 4'd1, 3'b000, 4'h0, 32'h0);
        wait_drain();

        // Illegal first beats: unsupported burstseq, zero length, reserved command
        push(ERR, 1'b1, 1'b0, 32'h0);
        issue(CMD_WR, 5'd5, 4'd1, 3'b001, 4'hF, 32'hFFFF_FFFF);
        push(ERR, 1'b1, 1'b0, 32'h0);
        issue(CMD_WR, 5'd5, 4'd0, 3'b000, 4'hF, 32'hFFFF_FFFF);
        push(ERR, 1'b1, 1'b0, 32'h0);
        issue(3'b011, 5'd5, 4'd1, 3'b000, 4'hF, 32'hFFFF_FFFF);
        push(DVA, 1'b1, 1'b1, 32'h0000_5678);
        issue(CMD_RD, 5'd5, 4'd1, 3'b000, 4'h0, 32'h0);
        wait_drain();

        // Write burst with idle gaps between beats
        push(DVA, 1'b1, 1'b0, 32'h0);
        issue(CMD_WR, 5'd10, 4'd3, 3'b000, 4'hF, 32'hC0C0_C0C0);
        idle(2);
        issue(CMD_WR, 5'd0, 4'd0, 3'b000, 4'hF, 32'hC1C1_C1C1);
        idle(3);
        issue(CMD_WR, 5'd0, 4'd0, 3'b000, 4'hF, 32'hC2C2_C2C2);
        push(DVA, 1'b0, 1'b1, 32'hC0C0_C0C0);
        push(DVA, 1'b0, 1'b1, 32'hC1C1_C1C1);
        push(DVA, 1'b1, 1'b1, 32'hC2C2_C2C2);
        issue(CMD_RD, 5'd10, 4'd3, 3'b000, 4'h0, 32'h0);
        wait_drain();

        // Read issued mid write burst aborts it after one written beat
        push(ERR, 1'b1, 1'b0, 32'h0);
        issue(CMD_WR, 5'd20, 4'd3, 3'b000, 4'hF, 32'hD0D0_D0D0);
        issue(CMD_RD, 5'd0, 4'd1, 3'b000, 4'hF, 32'hD1D1_D1D1);
        push(DVA, 1'b0, 1'b1, 32'hD0D0_D0D0);
        push(DVA, 1'b0, 1'b1, 32'h0);
        push(DVA, 1'b1, 1'b1, 32'h0);
        issue(CMD_RD, 5'd20, 4'd3, 3'b000, 4'h0, 32'h0);
        wait_drain();

        // Reset during beat 2 of a 4-beat read
        mon_en = 1'b0;
        issue(CMD_RD, 5'd30, 4'd4, 3'b000, 4'h0, 32'h0);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_beat2", bus.sdata, 32'hA1A1_A1A1);
        #2 rst = 1'b1;
        #1;
        check("mid_rst_sresp", {30'd0, bus.sresp}, 32'd0);
        check("mid_rst_sresplast", {31'd0, bus.sresplast}, 32'd0);
        check("mid_rst_sdata", bus.sdata, 32'd0);
        @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_scmdaccept", {31'd0, bus.scmdaccept}, 32'd1);
        check("post_rst_sresp", {30'd0, bus.sresp}, 32'd0);
        mon_en = 1'b1;

        // Memory was cleared by reset
        push(DVA, 1'b0, 1'b1, 32'h0);
        push(DVA, 1'b1, 1'b1, 32'h0);
        issue(CMD_RD, 5'd30, 4'd2, 3'b000, 4'h0, 32'h0);
        wait_drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
